// File: rtl/stopwatch_pkg.sv
// Shared types and 7-segment constants for the stopwatch_lap design.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    RunHold = 1'b0,
    RunGo   = 1'b1
  } run_e;

  localparam bcd_t BcdMax = 4'd9;

  localparam logic [6:0] Seg0     = 7'h40;
  localparam logic [6:0] Seg1     = 7'h79;
  localparam logic [6:0] Seg2     = 7'h24;
  localparam logic [6:0] Seg3     = 7'h30;
  localparam logic [6:0] Seg4     = 7'h19;
  localparam logic [6:0] Seg5     = 7'h12;
  localparam logic [6:0] Seg6     = 7'h02;
  localparam logic [6:0] Seg7     = 7'h78;
  localparam logic [6:0] Seg8     = 7'h00;
  localparam logic [6:0] Seg9     = 7'h10;
  localparam logic [6:0] SegBlank = 7'h7F;

  function automatic logic [6:0] seg7(input bcd_t d);
    logic [6:0] pat;
    case (d)
      4'd0:    pat = Seg0;
      4'd1:    pat = Seg1;
      4'd2:    pat = Seg2;
      4'd3:    pat = Seg3;
      4'd4:    pat = Seg4;
      4'd5:    pat = Seg5;
      4'd6:    pat = Seg6;
      4'd7:    pat = Seg7;
      4'd8:    pat = Seg8;
      4'd9:    pat = Seg9;
      default: pat = SegBlank;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/stopwatch_btn_cond.sv
// Button conditioner: 2-flop synchroniser, optional debounce, falling-edge pulse.
// Debounce is built only when STOPWATCH_DEBOUNCE_EN is defined.
module stopwatch_btn_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic fall
);

  logic sync1_q, sync2_q, prev_q, stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic [CntW-1:0] cnt_q;
  logic            deb_q;

  // Any disagreement restarts the stability window; a flip is accepted once
  // the new level has persisted for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (sync2_q == deb_q) begin
      cnt_q <= '0;
    end else if (cnt_q >= CntW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q <= '0;
      deb_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stable = deb_q;
`else
  assign stable = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= stable;
    end
  end

  assign level = stable;
  assign fall  = prev_q & ~stable;

endmodule

// File: rtl/stopwatch_lap.sv
// BCD stopwatch with lap freeze, overflow flag and multiplexed 7-segment scan.
// Define STOPWATCH_DEBOUNCE_EN to debounce the buttons for DEBOUNCE_CYCLES.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int unsigned N_DIGITS        = 4,
  parameter int unsigned TICK_DIV        = 1000000,
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned DP_POS          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic                mclk,
  input  logic                rst_n,
  input  logic                btn_start,
  input  logic                btn_clear,
  input  logic                btn_lap,
  output logic [N_DIGITS-1:0] an,
  output logic [7:0]          seg,
  output logic                lap_active,
  output logic                ovf
);

  localparam int unsigned PresW    = $clog2(TICK_DIV);
  localparam int unsigned ScanCntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW     = $clog2(N_DIGITS);
  localparam logic [N_DIGITS-1:0] AnOne = {{(N_DIGITS-1){1'b0}}, 1'b1};

  logic start_fall, clear_lvl, lap_fall;
  logic unused_start_lvl, unused_lap_lvl;

  stopwatch_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
    .clk   (mclk),
    .rst_n (rst_n),
    .btn   (btn_start),
    .level (unused_start_lvl),
    .fall  (start_fall)
  );

  stopwatch_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
    .clk   (mclk),
    .rst_n (rst_n),
    .btn   (btn_clear),
    .level (clear_lvl),
    .fall  ()
  );

  stopwatch_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
    .clk   (mclk),
    .rst_n (rst_n),
    .btn   (btn_lap),
    .level (unused_lap_lvl),
    .fall  (lap_fall)
  );

  run_e                    run_q;
  logic [PresW-1:0]        presc_q;
  bcd_t [N_DIGITS-1:0]     count_q, count_inc, lap_q, disp;
  logic                    tick, wrap;

  assign tick = (run_q == RunGo) && (presc_q == PresW'(TICK_DIV - 1));

  // Ripple BCD increment; wrap is the carry out of the top digit.
  always_comb begin
    logic carry;
    carry     = 1'b1;
    count_inc = count_q;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (count_q[i] == BcdMax) begin
          count_inc[i] = '0;
        end else begin
          count_inc[i] = count_q[i] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= RunHold;
      presc_q    <= '0;
      count_q    <= '0;
      lap_q      <= '0;
      lap_active <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      // Start toggles even while clear is held.
      if (start_fall) begin
        run_q <= (run_q == RunGo) ? RunHold : RunGo;
      end
      if (clear_lvl) begin
        presc_q    <= '0;
        count_q    <= '0;
        lap_active <= 1'b0;
        ovf        <= 1'b0;
      end else begin
        if (run_q != RunGo || tick) begin
          presc_q <= '0;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
        if (tick) begin
          count_q <= count_inc;
          if (wrap) begin
            ovf <= 1'b1;
          end
        end
        if (lap_fall) begin
          if (!lap_active) begin
            lap_q      <= count_q;
            lap_active <= 1'b1;
          end else begin
            lap_active <= 1'b0;
          end
        end
      end
    end
  end

  assign disp = lap_active ? lap_q : count_q;

  logic [ScanCntW-1:0] scan_cnt_q;
  logic [IdxW-1:0]     scan_idx_q;
  logic                dp_n;

  assign dp_n = (32'(scan_idx_q) != DP_POS);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      an         <= '1;
      seg        <= 8'hFF;
    end else begin
      if (scan_cnt_q == ScanCntW'(SCAN_DIV - 1)) begin
        scan_cnt_q <= '0;
        scan_idx_q <= (scan_idx_q == IdxW'(N_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      an  <= ~(AnOne << scan_idx_q);
      seg <= {dp_n, seg7(disp[scan_idx_q])};
    end
  end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Scoreboard bench for stopwatch_lap: integer reference model pushes the expected
// outputs each cycle; a separate monitor pops and compares on the falling edge.
module tb_stopwatch_lap;

  localparam int unsigned NDig    = 4;
  localparam int unsigned TickDiv = 2;
  localparam int unsigned ScanDiv = 4;
  localparam int unsigned DpPos   = 2;

  logic       mclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic [3:0] an;
  logic [7:0] seg;
  logic       lap_active, ovf;

  stopwatch_lap #(
    .N_DIGITS (NDig),
    .TICK_DIV (TickDiv),
    .SCAN_DIV (ScanDiv),
    .DP_POS   (DpPos)
  ) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .btn_lap    (btn_lap),
    .an         (an),
    .seg        (seg),
    .lap_active (lap_active),
    .ovf        (ovf)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       lap;
    logic       ovf;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int m_count = 0, m_lap = 0, m_presc = 0, m_scan_cnt = 0, m_scan_idx = 0, m_cycle = 0;
  bit m_run = 0, m_lap_on = 0, m_ovf = 0;
  // Past raw button samples, [0] newest.
  bit [2:0] h_start = '0, h_clear = '0, h_lap = '0;

  function automatic int p10(input int k);
    int r = 1;
    repeat (k) r = r * 10;
    return r;
  endfunction

  always @(posedge mclk) begin
    obs_t e;
    int   shown, digit;
    bit   tick, clr, sf, lf;
    m_cycle++;
    if (!rst_n) begin
      m_count = 0; m_lap = 0; m_presc = 0; m_scan_cnt = 0; m_scan_idx = 0;
      m_run = 0; m_lap_on = 0; m_ovf = 0;
      h_start = '0; h_clear = '0; h_lap = '0;
      e.an = 4'hF; e.seg = 8'hFF; e.lap = 1'b0; e.ovf = 1'b0;
    end else begin
      clr   = h_clear[1];
      sf    = h_start[2] & ~h_start[1];
      lf    = h_lap[2] & ~h_lap[1];
      shown = m_lap_on ? m_lap : m_count;
      digit = (shown / p10(m_scan_idx)) % 10;
      e.an  = ~(4'b0001 << m_scan_idx);
      e.seg = {(m_scan_idx == DpPos) ? 1'b0 : 1'b1, seg_ref[digit]};
      tick  = m_run && (m_presc == TickDiv - 1);
      if (sf) m_run = !m_run;
      if (clr) begin
        m_count = 0; m_presc = 0; m_ovf = 0; m_lap_on = 0;
      end else begin
        if (lf) begin
          if (!m_lap_on) begin
            m_lap = m_count;
            m_lap_on = 1;
          end else begin
            m_lap_on = 0;
          end
        end
        m_presc = (!tick && (m_presc != 0 || sf ? 1 : 1) && (m_run ^ sf)) ? m_presc + 1 : 0;
        if (tick) begin
          if (m_count == p10(NDig) - 1) begin
            m_count = 0;
            m_ovf = 1;
          end else begin
            m_count++;
          end
        end
      end
      m_scan_cnt++;
      if (m_scan_cnt == ScanDiv) begin
        m_scan_cnt = 0;
        m_scan_idx = (m_scan_idx + 1) % NDig;
      end
      e.lap = m_lap_on;
      e.ovf = m_ovf;
      h_start = {h_start[1:0], btn_start};
      h_clear = {h_clear[1:0], btn_clear};
      h_lap   = {h_lap[1:0], btn_lap};
    end
    exp_q.push_back(e);
  end

  always @(negedge mclk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, lap_active, ovf} !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got an=%b seg=%h lap=%b ovf=%b, want an=%b seg=%h lap=%b ovf=%b",
                 m_cycle, an, seg, lap_active, ovf, e.an, e.seg, e.lap, e.ovf);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic pulse(input int which);
    if (which == 0) btn_start = 1'b1;
    else if (which == 1) btn_lap = 1'b1;
    else btn_clear = 1'b1;
    cyc(2);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    cyc(1);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    pulse(0);
    cyc(20 + $urandom_range(0, 10));
    pulse(0);
    cyc(200);
    pulse(0);
    cyc(30);
    pulse(1);
    cyc(40);
    pulse(1);
    cyc(10);
    btn_clear = 1'b1;
    cyc(20);
    btn_clear = 1'b0;
    cyc(30);
    if (!m_run) pulse(0);
    cyc(20500);
    pulse(2);
    cyc(20);
    repeat (4000) begin
      cyc(1);
      r = $urandom_range(0, 99);
      if (r < 3) btn_start = ~btn_start;
      else if (r < 5) btn_lap = ~btn_lap;
      else if (r < 6) btn_clear = ~btn_clear;
    end
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    cyc(10);
    if (!m_run) pulse(0);
    cyc(7 + $urandom_range(0, 5));
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset: got an=%b seg=%h, want an=1111 seg=ff", an, seg);
    end
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    pulse(0);
    cyc(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, meaning number of BCD digits and display positions (legal 2..8).
REQ-002 SHALL have parameter TICK_DIV, default 1000000, meaning mclk cycles per count increment (>=2).
REQ-003 SHALL have parameter SCAN_DIV, default 50000, meaning mclk cycles per display digit slot (>=2).
REQ-004 SHALL have parameter DP_POS, default 2, meaning digit index whose decimal point is lit.
REQ-005 SHALL have port mclk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port btn_start  input  1  run/hold toggle button, asynchronous.
REQ-008 SHALL have port btn_clear  input  1  clear button, active-high level, asynchronous.
REQ-009 SHALL have port btn_lap  input  1  lap freeze/release button, asynchronous.
REQ-010 SHALL have port an  output  N_DIGITS  digit enables, one-hot active-low.
REQ-011 SHALL have port seg  output  8  {dp,g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port lap_active  output  1  display shows frozen lap value.
REQ-013 SHALL have port ovf  output  1  sticky count wrap flag.

Function
REQ-014 SHALL pass each button through a 2-flop synchroniser and detect falling edges (1->0) on the conditioned signal.
REQ-015 SHALL toggle the run flag on each btn_start falling edge; the run flag is 0 after reset.
REQ-016 SHALL run a prescaler 0..TICK_DIV-1 only while run=1, emitting one tick at TICK_DIV-1; prescaler is held at 0 while run=0.
REQ-017 SHALL increment the N_DIGITS BCD count by 1 per tick, with digit carry at 9->0; all-9s wraps to all-0 and sets ovf.
REQ-018 SHALL, while conditioned btn_clear=1, hold count=0, prescaler=0, ovf=0, lap_active=0; run flag is unaffected.
REQ-019 SHALL, when clear and a tick coincide, give priority to clear; a start edge in the same cycle still toggles run.
REQ-020 SHALL, on a btn_lap falling edge with lap_active=0, capture count into a lap register and set lap_active; on the next edge, clear lap_active. Counting continues in both states.
REQ-021 SHALL display the lap register when lap_active=1, else the live count.
REQ-022 SHALL rotate the scan index 0..N_DIGITS-1 every SCAN_DIV cycles, digit 0 (least significant) first, wrapping to 0.
REQ-023 SHALL register an and seg; seg decodes the selected digit (0-9 standard patterns); dp is 0 only when scan index = DP_POS.
REQ-024 SHALL show button-to-state latency of 3 mclk cycles (2 sync + edge), excluding debounce.

Reset
REQ-025 SHALL, on rst_n=0, force immediately: an all 1, seg 8'hFF, run=0, count=0, lap register=0, prescaler=0, scan index=0, lap_active=0, ovf=0, and synchroniser flops to 0.
REQ-026 SHALL enable digit 0 on the first mclk edge after rst_n deasserts; a reset mid-count discards all state.

Configuration
REQ-027 SHALL, with STOPWATCH_DEBOUNCE_EN defined, accept a synchronised button level change only after it is stable for DEBOUNCE_CYCLES (parameter, default 100000) consecutive cycles, adding that latency.
REQ-028 SHALL, without STOPWATCH_DEBOUNCE_EN, use the synchronised level directly; the DEBOUNCE_CYCLES parameter is then ignored.

Structure
REQ-029 SHALL place the 7-segment pattern constants (digits 0-9, blank) and the BCD digit type in package stopwatch_pkg.
REQ-030 SHALL implement button conditioning (sync, optional debounce, falling-edge pulse) in sub-module stopwatch_btn_cond, instantiated three times.

Verification (N_DIGITS=4, TICK_DIV=2, SCAN_DIV=4, DP_POS=2, no debounce)
REQ-031 Reset, then pulse btn_start 1->0 -> run=1 three cycles after the fall; count reaches 0005 after 10 more cycles.
REQ-032 Run to 0055, pulse btn_start -> count holds at 0055 for 200 cycles; pulse again -> 0056 two cycles after run re-asserts.
REQ-033 Assert btn_clear while running for 20 cycles -> count 0000 throughout; release -> counting resumes from 0000 (run still 1).
REQ-034 At count 0012, pulse btn_lap -> lap_active=1, displayed digits read 0012 while the live count advances; pulse again -> live count shown.
REQ-035 Preload/run to 9999, next tick -> count 0000, ovf=1; ovf stays 1 until btn_clear.
REQ-036 Scan check -> an cycles 1110,1101,1011,0111 every 4 cycles; seg[7]=0 only while an=1011; rst_n low mid-scan -> an=1111, seg=FF at once.
